// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - IEEE-754 format derivation, special constants, divider FSM and rounding-mode types
package fp_pkg;

  function automatic int fp_exp_w(input int width);
    return (width == 64) ? 11 : (width == 32) ? 8 : 5;
  endfunction

  function automatic int fp_mant_w(input int width);
    return width - fp_exp_w(width) - 1;
  endfunction

  function automatic int fp_exp_bias(input int width);
    return (1 << (fp_exp_w(width) - 1)) - 1;
  endfunction

  // Constants are built 64 bits wide; users slice them down to their own WIDTH.
  function automatic logic [63:0] fp_inf(input int width);
    return ((64'd1 << fp_exp_w(width)) - 64'd1) << fp_mant_w(width);
  endfunction

  function automatic logic [63:0] fp_qnan(input int width);
    return fp_inf(width) | (64'd1 << (fp_mant_w(width) - 1));
  endfunction

  localparam logic [63:0] FP_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NORM   = 3'd1,
    S_DIVIDE = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } fp_state_t;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RTZ = 2'd1,
    RM_RDN = 2'd2,
    RM_RUP = 2'd3
  } round_mode_t;

endpackage

// File: rtl/grs_rounder.sv
// rtl/grs_rounder.sv - guard/round/sticky rounder; the increment ripples through the packed exponent:fraction
module grs_rounder
  import fp_pkg::*;
#(
  parameter int W = 15
) (
  input  logic [1:0]   mode,
  input  logic         sign,
  input  logic [W-1:0] value,
  input  logic         guard,
  input  logic         round_bit,
  input  logic         sticky,
  output logic [W-1:0] rounded
);

  logic inexact;
  logic up;

  always_comb begin
    inexact = guard | round_bit | sticky;
    case (round_mode_t'(mode))
      RM_RNE:  up = guard & (round_bit | sticky | value[0]);
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = sign & inexact;
      RM_RUP:  up = ~sign & inexact;
      default: up = 1'b0;
    endcase
    rounded = value + {{(W-1){1'b0}}, up};
  end

endmodule

// File: rtl/fp_div.sv
// rtl/fp_div.sv - multicycle IEEE-754 divider (restoring, round-to-nearest-even)
// Optional FP_DIV_FLAGS_EN adds the {NV,DZ,OF,UF} flags port.
module fp_div
  import fp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int EXP_W  = fp_exp_w(WIDTH);
  localparam int MANT_W = fp_mant_w(WIDTH);
  localparam int BIAS   = fp_exp_bias(WIDTH);
  localparam int XW     = EXP_W + 3;
  localparam int LZW    = $clog2(MANT_W + 2);
  localparam int CW     = $clog2(MANT_W + 3);

  localparam logic [63:0]          INF64     = fp_inf(WIDTH);
  localparam logic [63:0]          QNAN64    = fp_qnan(WIDTH);
  localparam logic [WIDTH-2:0]     INF_MAG   = INF64[WIDTH-2:0];
  localparam logic [WIDTH-2:0]     ZERO_MAG  = FP_ZERO[WIDTH-2:0];
  localparam logic [WIDTH-1:0]     QNAN      = QNAN64[WIDTH-1:0];
  localparam logic signed [XW-1:0] ONE_X     = XW'(1);
  localparam logic signed [XW-1:0] BIAS_X    = XW'(BIAS);
  localparam logic signed [XW-1:0] MAX_EXP_X = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] SH_MAX_X  = XW'(MANT_W + 3);
  localparam logic [CW-1:0]        LAST_BIT  = CW'(MANT_W + 2);

  fp_state_t             state;
  logic                  norm_step;
  logic [WIDTH-1:0]      a_q, b_q;
  logic                  sign_q;
  logic [MANT_W:0]       na_q, nb_q;
  logic signed [XW-1:0]  xa_q, xb_q, exp_q;
  logic                  spec_hit;
  logic [WIDTH-1:0]      spec_res;
  logic [MANT_W+1:0]     rem_q;
  logic [MANT_W+2:0]     quot_q;
  logic [CW-1:0]         cnt_q;

  logic [EXP_W-1:0]      ea, eb;
  logic [MANT_W-1:0]     fa, fb;
  logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
  logic [MANT_W:0]       ma, mb;
  logic [LZW-1:0]        lza, lzb;
  logic                  sp_hit;
  logic [WIDTH-1:0]      sp_res;
`ifdef FP_DIV_FLAGS_EN
  logic [3:0]            sp_flags;
`endif

  function automatic logic [LZW-1:0] lzc(input logic [MANT_W:0] m);
    logic [LZW-1:0] n;
    n = '0;
    for (int i = 0; i <= MANT_W; i++)
      if (m[i]) n = LZW'(MANT_W - i);
    return n;
  endfunction

  // Operand classification and special-case resolution from the captured operands.
  always_comb begin
    ea     = a_q[WIDTH-2:MANT_W];
    eb     = b_q[WIDTH-2:MANT_W];
    fa     = a_q[MANT_W-1:0];
    fb     = b_q[MANT_W-1:0];
    sgn    = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    a_nan  = (&ea) & (|fa);
    b_nan  = (&eb) & (|fb);
    a_inf  = (&ea) & ~(|fa);
    b_inf  = (&eb) & ~(|fb);
    a_zero = ~(|ea) & ~(|fa);
    b_zero = ~(|eb) & ~(|fb);
    ma     = {|ea, fa};
    mb     = {|eb, fb};
    lza    = lzc(ma);
    lzb    = lzc(mb);
    sp_hit = 1'b1;
    sp_res = '0;
`ifdef FP_DIV_FLAGS_EN
    sp_flags = 4'b0000;
`endif
    if (a_nan) begin
      sp_res = a_q;
    end else if (b_nan) begin
      sp_res = b_q;
    end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
      sp_res = QNAN;
`ifdef FP_DIV_FLAGS_EN
      sp_flags = 4'b1000;
`endif
    end else if (b_zero) begin
      sp_res = {sgn, INF_MAG};
`ifdef FP_DIV_FLAGS_EN
      sp_flags = {1'b0, ~a_inf, 2'b00};
`endif
    end else if (a_inf) begin
      sp_res = {sgn, INF_MAG};
    end else if (a_zero | b_inf) begin
      sp_res = {sgn, ZERO_MAG};
    end else begin
      sp_hit = 1'b0;
    end
  end

  logic              q_bit;
  logic [MANT_W+1:0] rem_sub;

  always_comb begin
    q_bit   = rem_q >= {1'b0, nb_q};
    rem_sub = q_bit ? rem_q - {1'b0, nb_q} : rem_q;
  end

  // Tiny quotients are denormalised by shifting right, lost bits folding into sticky.
  logic                 tiny;
  logic signed [XW-1:0] shv;
  logic [MANT_W+2:0]    shifted;
  logic                 sh_sticky;
  logic                 r_g, r_r, r_s;
  logic [WIDTH-2:0]     rnd_in, rnd_out;
  logic                 ovf;
  logic [WIDTH-1:0]     dp_res;

  always_comb begin
    tiny      = exp_q[XW-1] | (exp_q == '0);
    shv       = ONE_X - exp_q;
    shifted   = quot_q;
    sh_sticky = 1'b0;
    if (tiny) begin
      if (shv > SH_MAX_X) begin
        shifted   = '0;
        sh_sticky = |quot_q;
      end else begin
        shifted   = quot_q >> shv;
        sh_sticky = |(quot_q & ~({(MANT_W+3){1'b1}} << shv));
      end
    end
    r_g    = shifted[1];
    r_r    = shifted[0];
    r_s    = sh_sticky | (|rem_q);
    rnd_in = {(tiny ? {EXP_W{1'b0}} : exp_q[EXP_W-1:0]), shifted[MANT_W+1:2]};
  end

  grs_rounder #(.W(WIDTH-1)) u_rnd (
    .mode      (RM_RNE),
    .sign      (sign_q),
    .value     (rnd_in),
    .guard     (r_g),
    .round_bit (r_r),
    .sticky    (r_s),
    .rounded   (rnd_out)
  );

  assign ovf    = (~tiny & (exp_q >= MAX_EXP_X)) | (&rnd_out[WIDTH-2:MANT_W]);
  assign dp_res = ovf ? {sign_q, INF_MAG} : {sign_q, rnd_out};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      norm_step <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      na_q      <= '0;
      nb_q      <= '0;
      xa_q      <= '0;
      xb_q      <= '0;
      exp_q     <= '0;
      spec_hit  <= 1'b0;
      spec_res  <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      cnt_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q       <= a;
            b_q       <= b;
            in_ready  <= 1'b0;
            norm_step <= 1'b0;
            state     <= S_NORM;
          end
        end
        S_NORM: begin
          if (!norm_step) begin
            na_q      <= ma << lza;
            nb_q      <= mb << lzb;
            xa_q      <= ((ea == '0) ? ONE_X : XW'(ea)) - XW'(lza);
            xb_q      <= ((eb == '0) ? ONE_X : XW'(eb)) - XW'(lzb);
            sign_q    <= sgn;
            spec_hit  <= sp_hit;
            spec_res  <= sp_res;
            norm_step <= 1'b1;
          end else begin
            // Pre-shift a smaller dividend so the quotient lands in [1,2).
            rem_q  <= (na_q < nb_q) ? {na_q, 1'b0} : {1'b0, na_q};
            exp_q  <= xa_q - xb_q + BIAS_X - ((na_q < nb_q) ? ONE_X : '0);
            quot_q <= '0;
            cnt_q  <= '0;
            state  <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          rem_q  <= rem_sub << 1;
          quot_q <= {quot_q[MANT_W+1:0], q_bit};
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) state <= S_ROUND;
        end
        S_ROUND: begin
          result    <= spec_hit ? spec_res : dp_res;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FP_DIV_FLAGS_EN
  logic [3:0] spec_flags_q;
  logic [3:0] dp_flags;

  assign dp_flags = {2'b00, ovf, tiny & (r_g | r_r | r_s)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_flags_q <= '0;
      flags        <= '0;
    end else begin
      if (state == S_NORM && !norm_step) spec_flags_q <= sp_flags;
      if (state == S_ROUND) flags <= spec_hit ? spec_flags_q : dp_flags;
    end
  end
`endif

endmodule

// File: tb/tb_fp_div.sv
// tb/tb_fp_div.sv - fp16 fp_div bench: directed corner cases plus random operands against a real-arithmetic model
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, result;
`ifdef FP_DIV_FLAGS_EN
  logic [3:0]  flags;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_div #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef FP_DIV_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic real pow2(input int n);
    real p;
    p = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) p = p * 2.0;
    else        for (int i = 0; i < -n; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic real to_real(input logic [15:0] x);
    int m;
    m = int'(x[9:0]);
    if (x[14:10] == 5'd0) return m * pow2(-24);
    return (m + 1024) * pow2(int'(x[14:10]) - 25);
  endfunction

  // Reference: exact quotient in real arithmetic, then RNE to fp16 by scaling to an integer significand.
  task automatic ref_div(input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic [3:0] f);
    logic s;
    bit   xn, yn, xi, yi, xz, yz, tiny;
    real  v, sc, ip, fr;
    int   e, ii;
    s  = x[15] ^ y[15];
    xn = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    yn = (y[14:10] == 5'h1F) && (y[9:0] != 10'd0);
    xi = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    yi = (y[14:10] == 5'h1F) && (y[9:0] == 10'd0);
    xz = (x[14:0] == 15'd0);
    yz = (y[14:0] == 15'd0);
    f  = 4'b0000;
    r  = 16'h0000;
    if (xn) r = x;
    else if (yn) r = y;
    else if ((xz && yz) || (xi && yi)) begin r = 16'h7E00; f = 4'b1000; end
    else if (xi) r = {s, 15'h7C00};
    else if (yz) begin r = {s, 15'h7C00}; f = 4'b0100; end
    else if (xz || yi) r = {s, 15'h0000};
    else begin
      v  = to_real(x) / to_real(y);
      e  = 0;
      sc = v;
      while (sc >= 2.0) begin sc = sc / 2.0; e++; end
      while (sc < 1.0) begin sc = sc * 2.0; e--; end
      tiny = (e < -14);
      if (tiny) e = -14;
      sc = v * pow2(10 - e);
      ip = $floor(sc);
      fr = sc - ip;
      ii = int'(ip);
      if (fr > 0.5 || (fr == 0.5 && (ii % 2) == 1)) ii++;
      if (ii == 2048) begin ii = 1024; e++; end
      if (e > 15) begin
        r = {s, 15'h7C00};
        f = 4'b0010;
      end else if (ii < 1024) begin
        r = {s, 5'd0, ii[9:0]};
      end else begin
        ii = ii - 1024;
        r  = {s, 5'(e + 15), ii[9:0]};
      end
      if (tiny && fr != 0.0) f[0] = 1'b1;
    end
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 7))
      0: r[14:0] = 15'h0000;
      1: r[14:0] = 15'h7C00;
      2: begin r[14:10] = 5'h1F; r[9] = 1'b1; end
      3: r[14:10] = 5'h00;
      default: ;
    endcase
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y, input int hold);
    logic [15:0] er;
    logic [3:0]  ef;
    int          lat;
    ref_div(x, y, er, ef);
    @(negedge clk);
    check({tag, ".in_ready"}, in_ready, 1);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".latency"}, lat, 16);
    check({tag, ".result"}, result, er);
`ifdef FP_DIV_FLAGS_EN
    check({tag, ".flags"}, flags, ef);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk);
      #1;
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_result"}, result, er);
      check({tag, ".hold_in_ready"}, in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".drop_valid"}, out_valid, 0);
    check({tag, ".ready_again"}, in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out_valid", out_valid, 0);
    check("reset.result", result, 0);
    check("reset.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("six_by_two", 16'h4600, 16'h4000, 0);
    run_op("one_third", 16'h3C00, 16'h4200, 0);
    run_op("denorm_tie", 16'h0001, 16'h4000, 0);
    run_op("div_zero", 16'h3C00, 16'h0000, 0);
    run_op("zero_zero", 16'h0000, 16'h0000, 0);
    run_op("overflow", 16'h7BFF, 16'h0001, 0);
    run_op("inf_zero", 16'hFC00, 16'h0000, 0);
    run_op("min_normal", 16'h0400, 16'h3C01, 0);
    run_op("backpressure", 16'h3C00, 16'h4200, 5);

    @(negedge clk);
    a = 16'h4600;
    b = 16'h3C00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort.out_valid", out_valid, 0);
    check("abort.result", result, 0);
    check("abort.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort.no_output", out_valid, 0);
    run_op("after_abort", 16'h4600, 16'h3C00, 0);

    for (int i = 0; i < 80; i++) begin
      run_op($sformatf("rand%0d", i), rand_op(), rand_op(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_div.md
FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 SHALL have parameter WIDTH, default 16, IEEE-754 operand/result width; legal values 16, 32, 64.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operands valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  dividend.
REQ-007 SHALL have port b  input  WIDTH  divisor.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port result  output  WIDTH  quotient a/b.

Function
REQ-011 SHALL accept operands on a rising edge where in_valid && in_ready, capturing a and b; later input changes SHALL be ignored until the next accept.
REQ-012 SHALL implement FSM IDLE -> NORM -> DIVIDE -> ROUND -> DONE -> IDLE; in_ready=1 only in IDLE.
REQ-013 NORM SHALL unpack operands, normalize denormal mantissas with a leading-zero shift, compute exponent ea-eb+BIAS, and pre-shift the dividend left 1 with exponent decrement when mant_a<mant_b, so the quotient lies in [1,2).
REQ-014 DIVIDE SHALL run a restoring divider producing one quotient bit per cycle for MANT_W+3 cycles (implicit, MANT_W fraction bits, guard, round); sticky = remainder nonzero.
REQ-015 ROUND SHALL apply round-to-nearest-even; mantissa round carry SHALL increment the exponent.
REQ-016 Exponent >= all-ones after rounding SHALL give signed infinity; exponent <= 0 SHALL right-shift the quotient (bits into sticky) before rounding, giving a denormal or zero, or the minimum normal if rounding carries.
REQ-017 Latency SHALL be fixed: out_valid rises MANT_W+6 edges after the accepting edge (fp16: 16), for every operand class.
REQ-018 Special cases SHALL be resolved in NORM and override the datapath result: NaN operand -> a if NaN else b; 0/0 or inf/inf -> QNAN (exp all ones, fraction MSB set, sign 0); finite/0 -> signed inf; inf/finite -> signed inf; 0/nonzero or finite/inf -> signed zero; sign = sign_a^sign_b.
REQ-019 In DONE, out_valid and result SHALL hold stable until out_ready=1; the handshake edge SHALL return the FSM to IDLE and drop out_valid.
REQ-020 Back-to-back operation SHALL NOT occur: the earliest next accept is the edge after return to IDLE.

Reset
REQ-021 rst_n low SHALL asynchronously force IDLE, in_ready=1 after reset release, out_valid=0, result=0, flags=0, and abort any operation in progress with no output.

Configuration
REQ-022 With macro FP_DIV_FLAGS_EN defined, SHALL add port flags  output  4  {NV,DZ,OF,UF}, valid with out_valid: NV for QNAN-generating cases, DZ for finite nonzero/0, OF for overflow to inf, UF for tiny inexact result.
REQ-023 Without FP_DIV_FLAGS_EN, the flags port and its logic SHALL be absent; result and timing SHALL be unchanged.

Structure
REQ-024 Shared package fp_pkg SHALL hold EXP_W/EXP_BIAS/MANT_W derivation per WIDTH, QNAN/zero/inf constants, the FSM state typedef, and the rounding-mode encoding.
REQ-025 Rounding SHALL use one instance of the existing grs_rounder sub-module (RNE mode); divider, normalizer, and FSM stay in fp_div.

Verification (WIDTH=16)
REQ-026 a=0x4600, b=0x4000 -> result 0x4200, out_valid exactly 16 edges after accept.
REQ-027 a=0x3C00, b=0x4200 -> 0x3555 (RNE of 1/3); a=0x0001, b=0x4000 -> 0x0000 (tie to even), UF=1.
REQ-028 a=0x3C00, b=0x0000 -> 0x7C00, DZ=1; a=0x0000, b=0x0000 -> 0x7E00, NV=1; a=0x7BFF, b=0x0001 -> 0x7C00, OF=1.
REQ-029 out_ready held low 5 cycles in DONE -> result and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready high -> in_ready=1 on the next cycle.
REQ-030 rst_n asserted mid-DIVIDE -> out_valid=0, result=0 immediately; a new accept after release produces a correct result with 16-edge latency.
